// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end: latches eight request lines into a pending register
// (per-line edge or level capture), masks them towards an external priority
// encoder, and runs the request/acknowledge/end-of-interrupt handshake with
// the CPU while holding the in-service interrupt ID.
module irq_pending_ctrl #(
  // When set, an accepted acknowledge returns straight to IDLE and eoi is ignored
  parameter bit AUTO_EOI = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic [7:0] mode_edge,
  input  logic [7:0] mask,
  output logic [7:0] pend_out,
  input  logic       enc_valid,
  input  logic [2:0] enc_code,
  output logic       irq_req,
  input  logic       irq_ack,
  output logic [2:0] irq_id,
  output logic       in_service,
  input  logic       eoi
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [7:0] prev_q;
  logic [7:0] pend_q, pend_d;
  logic [1:0] state_q, state_d;
  logic [2:0] id_q, id_d;

  logic [7:0] rise;
  logic [7:0] ack_clr;
  logic       ack_take;
  logic       eoi_take;

  // Handshake qualifiers: an ack only counts in REQ with a live encoder
  // result, and eoi only counts in SERVICE when software EOI is in use
  always_comb begin
    ack_take = (state_q == ST_REQ) && enc_valid && irq_ack;
    eoi_take = (state_q == ST_SERVICE) && eoi && !AUTO_EOI;
  end

  // Pending next-state: edge lines set on a rise and clear only on their own
  // ack (a simultaneous rise wins); level lines simply follow the input
  always_comb begin
    rise    = irq_in & ~prev_q;
    ack_clr = ack_take ? (8'h01 << enc_code) : 8'h00;
    pend_d  = (mode_edge & (rise | (pend_q & ~ack_clr)))
            | (~mode_edge & irq_in);
  end

  // Controller next-state and in-service ID capture
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!enc_valid) begin
          state_d = ST_IDLE;
        end else if (irq_ack) begin
          id_d    = enc_code;
          state_d = AUTO_EOI ? ST_IDLE : ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi_take) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; prev_q tracks irq_in even in reset so that a line
  // already high when reset releases is not mistaken for a fresh edge
  always_ff @(posedge clk) begin
    prev_q <= irq_in;
    if (rst) begin
      pend_q  <= 8'h00;
      state_q <= ST_IDLE;
      id_q    <= 3'd0;
    end else begin
      pend_q  <= pend_d;
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  // Outputs: in REQ the ID tracks the encoder live so a higher-priority
  // arrival can pre-empt before the CPU acknowledges
  always_comb begin
    pend_out   = pend_q & ~mask;
    irq_req    = (state_q == ST_REQ);
    in_service = (state_q == ST_SERVICE);
    irq_id     = (state_q == ST_REQ) ? enc_code : id_q;
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: one instance with software EOI and
// one with AUTO_EOI, each fed by a behavioural 8-input priority encoder.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  int         errors = 0;
  int         checks = 0;

  // Software-EOI instance signals
  logic       rst, irqAck, eoi, encValid, irqReq, inService;
  logic [7:0] irqIn, modeEdge, mask, pendOut;
  logic [2:0] encCode, irqId;

  // AUTO_EOI instance signals
  logic       aRst, aAck, aEoi, aEncValid, aReq, aInService;
  logic [7:0] aIrqIn, aPendOut;
  logic [2:0] aEncCode, aId;

  always #5 clk = ~clk;

  irq_pending_ctrl #(.AUTO_EOI(1'b0)) dut (
    .clk(clk), .rst(rst), .irq_in(irqIn), .mode_edge(modeEdge), .mask(mask),
    .pend_out(pendOut), .enc_valid(encValid), .enc_code(encCode),
    .irq_req(irqReq), .irq_ack(irqAck), .irq_id(irqId),
    .in_service(inService), .eoi(eoi)
  );

  irq_pending_ctrl #(.AUTO_EOI(1'b1)) dutAuto (
    .clk(clk), .rst(aRst), .irq_in(aIrqIn), .mode_edge(8'hFF), .mask(8'h00),
    .pend_out(aPendOut), .enc_valid(aEncValid), .enc_code(aEncCode),
    .irq_req(aReq), .irq_ack(aAck), .irq_id(aId),
    .in_service(aInService), .eoi(aEoi)
  );

  // Reference priority encoders: highest set bit wins
  always_comb begin
    encValid = |pendOut;
    encCode  = 3'd0;
    for (int i = 0; i < 8; i++) if (pendOut[i]) encCode = 3'(i);
  end

  always_comb begin
    aEncValid = |aPendOut;
    aEncCode  = 3'd0;
    for (int j = 0; j < 8; j++) if (aPendOut[j]) aEncCode = 3'(j);
  end

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hard time limit so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; irqIn = 8'h01; modeEdge = 8'hFF; mask = 8'h00; irqAck = 1'b0; eoi = 1'b0;
    aRst = 1'b1; aIrqIn = 8'h00; aAck = 1'b0; aEoi = 1'b0;

    // Reset values with line 0 already high
    applyStimulus(2);
    checkOutput("rst_pend", pendOut, 8'h00);
    checkOutput("rst_req", 8'(irqReq), 8'd0);
    checkOutput("rst_insvc", 8'(inService), 8'd0);
    checkOutput("rst_id", 8'(irqId), 8'd0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1);
      checkOutput("held_pend", pendOut, 8'h00);
      checkOutput("held_req", 8'(irqReq), 8'd0);
    end
    irqIn = 8'h00;
    applyStimulus(2);

    // Single edge on line 5 through full handshake
    irqIn = 8'h20;
    applyStimulus(1);
    checkOutput("l5_pend", pendOut, 8'h20);
    checkOutput("l5_req_early", 8'(irqReq), 8'd0);
    applyStimulus(1);
    checkOutput("l5_req", 8'(irqReq), 8'd1);
    checkOutput("l5_id", 8'(irqId), 8'd5);
    irqAck = 1'b1;
    applyStimulus(1);
    irqAck = 1'b0;
    checkOutput("l5_insvc", 8'(inService), 8'd1);
    checkOutput("l5_pend_clr", pendOut, 8'h00);
    checkOutput("l5_svc_id", 8'(irqId), 8'd5);
    checkOutput("l5_svc_req", 8'(irqReq), 8'd0);
    applyStimulus(1);
    eoi = 1'b1;
    applyStimulus(1);
    eoi = 1'b0;
    checkOutput("l5_eoi", 8'(inService), 8'd0);
    irqIn = 8'h00;
    applyStimulus(1);

    // Lines 2 and 6 together: priority then second request after eoi
    irqIn = 8'h44;
    applyStimulus(1);
    checkOutput("l26_pend", pendOut, 8'h44);
    applyStimulus(1);
    checkOutput("l26_id", 8'(irqId), 8'd6);
    irqAck = 1'b1;
    applyStimulus(1);
    irqAck = 1'b0;
    checkOutput("l26_insvc", 8'(inService), 8'd1);
    checkOutput("l26_pend_ack", pendOut, 8'h04);
    eoi = 1'b1;
    applyStimulus(1);
    eoi = 1'b0;
    checkOutput("l26_idle_req", 8'(irqReq), 8'd0);
    applyStimulus(1);
    checkOutput("l2_req", 8'(irqReq), 8'd1);
    checkOutput("l2_id", 8'(irqId), 8'd2);
    irqAck = 1'b1;
    applyStimulus(1);
    irqAck = 1'b0;
    eoi = 1'b1;
    applyStimulus(1);
    eoi = 1'b0;
    irqIn = 8'h00;
    applyStimulus(1);
    checkOutput("l26_clean", pendOut, 8'h00);

    // Line 3 level mode: ack does not clear, drop while in REQ
    modeEdge = 8'hF7; irqIn = 8'h08;
    applyStimulus(1);
    checkOutput("lv3_pend", pendOut, 8'h08);
    applyStimulus(1);
    checkOutput("lv3_id", 8'(irqId), 8'd3);
    irqAck = 1'b1;
    applyStimulus(1);
    irqAck = 1'b0;
    checkOutput("lv3_insvc", 8'(inService), 8'd1);
    checkOutput("lv3_pend_kept", pendOut, 8'h08);
    eoi = 1'b1;
    applyStimulus(1);
    eoi = 1'b0;
    applyStimulus(1);
    checkOutput("lv3_rereq", 8'(irqReq), 8'd1);
    checkOutput("lv3_reid", 8'(irqId), 8'd3);
    irqIn = 8'h00;
    applyStimulus(1);
    irqAck = 1'b1;
    applyStimulus(1);
    irqAck = 1'b0;
    checkOutput("lv3_drop_req", 8'(irqReq), 8'd0);
    checkOutput("lv3_drop_ackign", 8'(inService), 8'd0);
    checkOutput("lv3_drop_pend", pendOut, 8'h00);

    // Line 7 masked while requesting, then unmasked
    modeEdge = 8'hFF; irqIn = 8'h80;
    applyStimulus(2);
    checkOutput("l7_req", 8'(irqReq), 8'd1);
    checkOutput("l7_id", 8'(irqId), 8'd7);
    mask = 8'h80;
    #1;
    checkOutput("l7_masked", pendOut, 8'h00);
    applyStimulus(1);
    checkOutput("l7_mask_idle", 8'(irqReq), 8'd0);
    mask = 8'h00;
    #1;
    checkOutput("l7_kept", pendOut, 8'h80);
    applyStimulus(1);
    checkOutput("l7_rereq", 8'(irqReq), 8'd1);
    checkOutput("l7_reid", 8'(irqId), 8'd7);
    irqAck = 1'b1;
    applyStimulus(1);
    irqAck = 1'b0;
    eoi = 1'b1;
    applyStimulus(1);
    eoi = 1'b0;
    irqIn = 8'h00;
    applyStimulus(1);

    // Rise on line 1 coincides with its own ack: set wins
    irqIn = 8'h02;
    applyStimulus(1);
    irqIn = 8'h00;
    applyStimulus(1);
    checkOutput("l1_id", 8'(irqId), 8'd1);
    irqIn = 8'h02; irqAck = 1'b1;
    applyStimulus(1);
    irqAck = 1'b0; irqIn = 8'h00;
    checkOutput("l1_insvc", 8'(inService), 8'd1);
    checkOutput("l1_setwins", pendOut, 8'h02);
    eoi = 1'b1;
    applyStimulus(1);
    eoi = 1'b0;
    checkOutput("l1_idle", 8'(irqReq), 8'd0);
    applyStimulus(1);
    checkOutput("l1_rereq", 8'(irqReq), 8'd1);
    checkOutput("l1_reid", 8'(irqId), 8'd1);
    irqAck = 1'b1;
    applyStimulus(1);
    irqAck = 1'b0;
    checkOutput("l1_pend_clr", pendOut, 8'h00);
    eoi = 1'b1;
    applyStimulus(1);
    eoi = 1'b0;

    // Reset during SERVICE
    irqIn = 8'h10;
    applyStimulus(2);
    irqAck = 1'b1;
    applyStimulus(1);
    irqAck = 1'b0;
    checkOutput("mid_insvc", 8'(inService), 8'd1);
    irqIn = 8'h10;
    applyStimulus(1);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checkOutput("mid_rst_insvc", 8'(inService), 8'd0);
    checkOutput("mid_rst_pend", pendOut, 8'h00);
    applyStimulus(2);
    checkOutput("mid_rst_noreq", 8'(irqReq), 8'd0);
    irqIn = 8'h00;

    // AUTO_EOI instance: ack returns to IDLE, eoi has no effect
    aRst = 1'b0;
    applyStimulus(1);
    aIrqIn = 8'h08;
    applyStimulus(1);
    checkOutput("a_pend", aPendOut, 8'h08);
    applyStimulus(1);
    checkOutput("a_req", 8'(aReq), 8'd1);
    checkOutput("a_id", 8'(aId), 8'd3);
    aAck = 1'b1;
    applyStimulus(1);
    aAck = 1'b0;
    checkOutput("a_ack_insvc", 8'(aInService), 8'd0);
    checkOutput("a_ack_req", 8'(aReq), 8'd0);
    checkOutput("a_ack_pend", aPendOut, 8'h00);
    checkOutput("a_ack_id", 8'(aId), 8'd3);
    aIrqIn = 8'h14;
    applyStimulus(2);
    checkOutput("a_id4", 8'(aId), 8'd4);
    aAck = 1'b1; aEoi = 1'b1;
    applyStimulus(1);
    aAck = 1'b0;
    checkOutput("a_eoi_insvc", 8'(aInService), 8'd0);
    checkOutput("a_pend4", aPendOut, 8'h04);
    applyStimulus(1);
    aEoi = 1'b0;
    checkOutput("a_req2", 8'(aReq), 8'd1);
    checkOutput("a_id2", 8'(aId), 8'd2);
    checkOutput("a_eoi_noeffect", 8'(aInService), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
- Interrupt front-end for the 8-input priority encoder.
- Captures eight request lines into a pending register, each line in edge or level mode, and applies a mask.
- Drives the masked pending vector to the encoder and consumes the encoder's valid/code result.
- Runs a request/acknowledge/end-of-interrupt handshake towards the CPU and holds the in-service ID.

Parameters:
- AUTO_EOI, 0: when 1, the controller returns to IDLE on ack and never enters SERVICE; the eoi input is ignored.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  8  request lines, synchronous to clk.
- mode_edge  in  8  per line: 1 = rising-edge triggered, 0 = level triggered.
- mask  in  8  per line: 1 = masked; the line is still latched but not presented.
- pend_out  out  8  masked pending vector to the encoder, equal to pending & ~mask.
- enc_valid  in  1  encoder valid, combinationally derived from pend_out.
- enc_code  in  3  encoder code for the highest set bit of pend_out.
- irq_req  out  1  interrupt request to the CPU.
- irq_ack  in  1  CPU acknowledge, single-cycle pulse.
- irq_id  out  3  in REQ, follows enc_code live; in SERVICE, holds the latched ID.
- in_service  out  1  high while in SERVICE.
- eoi  in  1  end-of-interrupt, single-cycle pulse.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pending = 0, state = IDLE, irq_req = 0, irq_id = 0, in_service = 0, pend_out = 0.
  - prev_in loads irq_in, so a line already high at reset release is not seen as an edge.
- Edge detection: prev_in <= irq_in every cycle. A rise on line i is irq_in[i] & ~prev_in[i].
- Edge-mode line (mode_edge[i]=1):
  - pending[i] sets on a rise.
  - pending[i] clears only when acknowledged, i.e. irq_ack accepted in REQ with enc_code == i.
  - A rise and a clear on the same line in the same cycle: the set wins and pending stays 1.
  - Multiple rises before ack collapse into one pending bit.
- Level-mode line (mode_edge[i]=0): pending[i] <= irq_in[i] every cycle; ack does not clear it.
- Mode change on a line takes effect the next cycle. Switching edge->level discards any latched edge, since pending then follows the level.
- pend_out is registered-pending & ~mask, purely combinational from pending and mask. Masking never clears pending.
- Latency: irq_in rises at edge N; pending is set after edge N. enc_valid goes high in the same cycle (combinational). irq_req is 1 after edge N+1.
- FSM states:
  - IDLE: irq_req=0, in_service=0. If enc_valid=1, go to REQ.
  - REQ: irq_req=1, irq_id=enc_code (live, so priority can change before ack).
    - If enc_valid=0 (line masked or level dropped), go to IDLE; any irq_ack that cycle is ignored.
    - Else if irq_ack=1: latch irq_id <= enc_code and clear that line's pending if it is edge mode. Go to SERVICE, or to IDLE if AUTO_EOI=1.
  - SERVICE: irq_req=0, in_service=1, irq_id held.
    - New requests keep latching, including the same line.
    - eoi=1: go to IDLE; the next request is raised no earlier than one cycle after that.
- Ignored inputs:
  - irq_ack in IDLE or SERVICE.
  - eoi outside SERVICE.
  - eoi when AUTO_EOI=1.
- Interaction: simultaneous irq_ack and eoi is only possible to act on in one state, so no conflict arises.
- Reset mid-operation, including during SERVICE: returns to IDLE with pending cleared the next cycle. No ack or eoi is required afterwards.
- irq_id is unchanged on transition to IDLE; it is don't-care while irq_req=0 and in_service=0.

Test Plan:
- Reset release with irq_in=8'h01 held, mode_edge=8'hFF, mask=0 -> no edge is detected; pend_out=0 and irq_req stays 0 for 10 cycles.
- Edge on line 5 (mode_edge=8'hFF) -> pend_out=8'h20 next cycle and irq_req=1 the cycle after with irq_id=5. Ack -> in_service=1, pend_out=0. Eoi -> in_service=0.
- Lines 2 and 6 rise together in edge mode -> irq_id=6. Ack -> pend_out=8'h04. Eoi -> irq_req re-asserts with irq_id=2.
- Line 3 in level mode held high, mask=0 -> ack, then eoi -> irq_req=1 again with irq_id=3. Drop irq_in[3] while in REQ -> REQ goes to IDLE and irq_req falls within 2 cycles.
- Line 7 pending and irq_req=1, then set mask=8'h80 -> enc_valid=0, REQ goes to IDLE. Unmask -> request returns with irq_id=7 and the pending bit is preserved.
- Rise on line 1 in the same cycle as the ack of line 1 -> pending[1] stays 1. After eoi, a second request with irq_id=1 follows. AUTO_EOI=1 variant: no SERVICE state, and eoi has no effect.
